burst_axi_master: RTL

- Parametrised successor to the single-beat host-to-AXI4 master.
- Converts one host command into one AXI4 INCR burst of 1..MAX_BEATS beats, read or write.
- Configurable data and address width; host data is streamed with valid/ready; latched status uses done/error/invalid flags.
- Sits between a host-side controller (DMA engine, CPU bridge) and an AXI4 interconnect slave port.

---
 rtl/burst_axi_master.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/burst_axi_master.sv
// rtl/burst_axi_master.sv - host command to AXI4 INCR burst master
//
// Turns one host command (read or write, 1..MAX_BEATS beats) into a single
// AXI4 INCR burst. Host write beats stream in over i_wvalid/o_wready and host
// read beats stream out over o_rvalid/i_rready. Both data paths are
// combinational pass-throughs while the burst is in its data phase.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rw, i_addr, i_size,     command (00 none, 01 read, 10 write, 11 bad),
//   i_len                     start address, log2 bytes/beat, beats-1
//   i_wvalid/o_wready/i_wdata host write beat stream
//   o_rvalid/i_rready/o_rdata/o_rlast  host read beat stream
//   o_busy, o_done, o_error, o_invalid  status; i_clear releases DONE/INVAL
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master port
module burst_axi_master #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [1:0]          i_rw,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_size,
  input  logic [7:0]          i_len,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rlast,
  output logic                o_busy,
  input  logic                i_clear,
  output logic                o_done,
  output logic                o_error,
  output logic                o_invalid,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_bready,
  input  logic                m_axi_bvalid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_rready,
  input  logic                m_axi_rvalid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast
);

  localparam int NB    = DATA_W / 8;
  localparam int LG_NB = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, INVAL
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [7:0]          len_q;
  logic [8:0]          cnt;
  logic                aw_v, ar_v, b_rdy;
  logic                busy_q, done_q, inval_q, error_q;

  // Command validation, evaluated on the raw command inputs in IDLE.
  logic [16:0]         span;
  logic [17:0]         end_off;
  logic                cmd_bad;

  always_comb begin
    // Bytes covered by the burst; (255+1)<<7 still fits in 17 bits.
    span    = ({9'd0, i_len} + 17'd1) << i_size;
    end_off = {6'd0, i_addr[11:0]} + {1'b0, span};
    cmd_bad = (i_rw == 2'b11)
            | (i_size > 3'(LG_NB))
            | ((i_addr & ((ADDR_W'(1) << i_size) - ADDR_W'(1))) != '0)
            | (({1'b0, i_len} + 9'd1) > 9'(MAX_BEATS))
            | (end_off > 18'd4096);
  end

  // Byte lanes of the current write beat. Only the low LG_NB address bits
  // matter, so the beat offset is truncated before the add.
  logic [LG_NB-1:0]    lane;
  logic [NB-1:0]       strb_base;
  logic [NB-1:0]       wstrb_c;
  logic                last_beat;

  always_comb begin
    lane = addr_q[LG_NB-1:0] + LG_NB'(cnt << size_q);
    // Align down to the beat size; at full bus width the mask wraps to 0.
    lane = lane & ~((LG_NB'(1) << size_q) - LG_NB'(1));
    for (int i = 0; i < NB; i++) begin
      strb_base[i] = (i < (1 << size_q));
    end
    wstrb_c   = strb_base << lane;
    last_beat = (cnt == {1'b0, len_q});
  end

  logic in_wd, in_rd;
  assign in_wd = (state == WR_DATA);
  assign in_rd = (state == RD_DATA);

  assign m_axi_awvalid = aw_v;
  assign m_axi_awaddr  = aw_v ? addr_q : '0;
  assign m_axi_awlen   = aw_v ? len_q  : '0;
  assign m_axi_awsize  = aw_v ? size_q : '0;
  assign m_axi_awburst = 2'b01;
  assign m_axi_arvalid = ar_v;
  assign m_axi_araddr  = ar_v ? addr_q : '0;
  assign m_axi_arlen   = ar_v ? len_q  : '0;
  assign m_axi_arsize  = ar_v ? size_q : '0;
  assign m_axi_arburst = 2'b01;

  assign m_axi_wvalid  = in_wd & i_wvalid;
  assign o_wready      = in_wd & m_axi_wready;
  assign m_axi_wdata   = in_wd ? i_wdata : '0;
  assign m_axi_wstrb   = in_wd ? wstrb_c : '0;
  assign m_axi_wlast   = in_wd & last_beat;
  assign m_axi_bready  = b_rdy;

  assign m_axi_rready  = in_rd & i_rready;
  assign o_rvalid      = in_rd & m_axi_rvalid;
  assign o_rdata       = in_rd ? m_axi_rdata : '0;
  assign o_rlast       = in_rd & m_axi_rlast;

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_invalid = inval_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      aw_v    <= 1'b0;
      ar_v    <= 1'b0;
      b_rdy   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inval_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A clear in IDLE blocks acceptance so a stale clear can never
          // race a new command.
          if (i_rw != 2'b00 && !i_clear) begin
            addr_q  <= i_addr;
            size_q  <= i_size;
            len_q   <= i_len;
            cnt     <= '0;
            error_q <= 1'b0;
            if (cmd_bad) begin
              state   <= INVAL;
              inval_q <= 1'b1;
            end else if (i_rw == 2'b10) begin
              state  <= WR_ADDR;
              aw_v   <= 1'b1;
              busy_q <= 1'b1;
            end else begin
              state  <= RD_ADDR;
              ar_v   <= 1'b1;
              busy_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) begin
            aw_v  <= 1'b0;
            state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (i_wvalid && m_axi_wready) begin
            cnt <= cnt + 9'd1;
            if (last_beat) begin
              state <= WR_RESP;
              b_rdy <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            b_rdy   <= 1'b0;
            error_q <= (m_axi_bresp != 2'b00);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            ar_v  <= 1'b0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid && i_rready) begin
            cnt <= cnt + 9'd1;
            // rlast must coincide exactly with the expected final beat.
            if (m_axi_rresp != 2'b00 || (m_axi_rlast != last_beat)) begin
              error_q <= 1'b1;
            end
            if (m_axi_rlast) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE, INVAL: begin
          if (i_clear) begin
            done_q  <= 1'b0;
            inval_q <= 1'b0;
            error_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
